// File: rtl/vout_pkg.sv
// Shared types and constants for the video-out raster timing generator.
package vout_pkg;

    localparam int unsigned VOUT_CW = 12;
    localparam int unsigned VOUT_TW = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_WAIT_RDY,
        ST_RUN
    } vout_state_e;

    typedef struct packed {
        logic [VOUT_CW-1:0] h_active;
        logic [VOUT_CW-1:0] h_fp;
        logic [VOUT_CW-1:0] h_sync;
        logic [VOUT_CW-1:0] h_bp;
        logic [VOUT_CW-1:0] v_active;
        logic [VOUT_CW-1:0] v_fp;
        logic [VOUT_CW-1:0] v_sync;
        logic [VOUT_CW-1:0] v_bp;
        logic               hs_pol;
        logic               vs_pol;
    } vout_geom_t;

    // A geometry is usable only if both axes have a visible region and a sync pulse.
    function automatic logic geom_ok(input logic [VOUT_CW-1:0] h_active,
                                     input logic [VOUT_CW-1:0] h_sync,
                                     input logic [VOUT_CW-1:0] v_active,
                                     input logic [VOUT_CW-1:0] v_sync);
        return (h_active != '0) && (h_sync != '0) && (v_active != '0) && (v_sync != '0);
    endfunction

endpackage

// File: rtl/vout_axis_cnt.sv
// One raster axis: wrap counter over active+fp+sync+bp with active/sync region decode.
module vout_axis_cnt
    import vout_pkg::*;
#(
    parameter int unsigned CW = VOUT_CW,
    parameter int unsigned TW = VOUT_TW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [CW-1:0] active_i,
    input  logic [CW-1:0] fp_i,
    input  logic [CW-1:0] sync_i,
    input  logic [CW-1:0] bp_i,
    output logic [TW-1:0] cnt_o,
    output logic          last_o_c,
    output logic          act_o_c,
    output logic          sync_o_c
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic [TW-1:0] sync_lo;
    logic [TW-1:0] sync_hi;
    logic [TW-1:0] total;

    // Field boundaries summed at counter width so four full-scale fields cannot overflow.
    assign sync_lo = TW'(active_i) + TW'(fp_i);
    assign sync_hi = sync_lo + TW'(sync_i);
    assign total   = sync_hi + TW'(bp_i);

    assign last_o_c = (cnt_q == (total - TW'(1)));
    assign act_o_c  = (cnt_q < TW'(active_i));
    assign sync_o_c = (cnt_q >= sync_lo) && (cnt_q < sync_hi);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o_c ? '0 : cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vout_timing_gen.sv
// Programmable raster timing generator (sync/DE/coordinates) for the video-out stage.
// Define VOUT_TG_FRAME_GATE_EN to hold each new frame until out_not_ready deasserts.
module vout_timing_gen
    import vout_pkg::*;
#(
    parameter int unsigned CW = VOUT_CW,
    parameter int unsigned TW = VOUT_TW
) (
    input  logic          pclk,
    input  logic          prst,
    input  logic          enable,
    input  logic [CW-1:0] h_active,
    input  logic [CW-1:0] h_fp,
    input  logic [CW-1:0] h_sync,
    input  logic [CW-1:0] h_bp,
    input  logic [CW-1:0] v_active,
    input  logic [CW-1:0] v_fp,
    input  logic [CW-1:0] v_sync,
    input  logic [CW-1:0] v_bp,
    input  logic          hs_pol,
    input  logic          vs_pol,
    input  logic          out_not_ready,
    output logic          vsync,
    output logic          hsync,
    output logic          de,
    output logic [CW-1:0] x_pos,
    output logic [CW-1:0] y_pos,
    output logic          frame_start,
    output logic          cfg_err
);

    vout_state_e   state_q;
    vout_geom_t    geom_q;
    vout_geom_t    geom_live;
    logic          gate_open;
    logic          run;
    logic          pix_act;
    logic [TW-1:0] hc;
    logic [TW-1:0] vc;
    logic          h_last;
    logic          h_act;
    logic          h_sync_raw;
    logic          v_last;
    logic          v_act;
    logic          v_sync_raw;

    logic          vsync_q;
    logic          hsync_q;
    logic          de_q;
    logic [CW-1:0] x_pos_q;
    logic [CW-1:0] y_pos_q;
    logic          frame_start_q;
    logic          cfg_err_q;

    assign geom_live = {h_active, h_fp, h_sync, h_bp,
                        v_active, v_fp, v_sync, v_bp, hs_pol, vs_pol};

`ifdef VOUT_TG_FRAME_GATE_EN
    assign gate_open = ~out_not_ready;
`else
    // Port kept for interface compatibility; the OR keeps it referenced without effect.
    assign gate_open = 1'b1 | out_not_ready;
`endif

    assign run     = (state_q == ST_RUN);
    assign pix_act = run && h_act && v_act;

    vout_axis_cnt #(.CW(CW), .TW(TW)) u_h_cnt (
        .clk_i    (pclk),
        .rst_i    (prst),
        .clr_i    (~run),
        .inc_i    (run),
        .active_i (geom_q.h_active),
        .fp_i     (geom_q.h_fp),
        .sync_i   (geom_q.h_sync),
        .bp_i     (geom_q.h_bp),
        .cnt_o    (hc),
        .last_o_c (h_last),
        .act_o_c  (h_act),
        .sync_o_c (h_sync_raw)
    );

    // Vertical axis advances once per line, so vsync edges stay line-aligned.
    vout_axis_cnt #(.CW(CW), .TW(TW)) u_v_cnt (
        .clk_i    (pclk),
        .rst_i    (prst),
        .clr_i    (~run),
        .inc_i    (run && h_last),
        .active_i (geom_q.v_active),
        .fp_i     (geom_q.v_fp),
        .sync_i   (geom_q.v_sync),
        .bp_i     (geom_q.v_bp),
        .cnt_o    (vc),
        .last_o_c (v_last),
        .act_o_c  (v_act),
        .sync_o_c (v_sync_raw)
    );

    // Frame sequencer plus registered raster outputs derived from the current counters.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q       <= ST_IDLE;
            geom_q        <= '0;
            cfg_err_q     <= 1'b0;
            vsync_q       <= 1'b0;
            hsync_q       <= 1'b0;
            de_q          <= 1'b0;
            x_pos_q       <= '0;
            y_pos_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            de_q          <= pix_act;
            hsync_q       <= (run && h_sync_raw) ^ ~geom_q.hs_pol;
            vsync_q       <= (run && v_sync_raw) ^ ~geom_q.vs_pol;
            frame_start_q <= run && (hc == '0) && (vc == '0);
            x_pos_q       <= pix_act ? hc[CW-1:0] : '0;
            y_pos_q       <= pix_act ? vc[CW-1:0] : '0;

            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    geom_q <= geom_live;
                    if (geom_ok(h_active, h_sync, v_active, v_sync)) begin
                        cfg_err_q <= 1'b0;
                        state_q   <= ST_WAIT_RDY;
                    end else begin
                        cfg_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_WAIT_RDY: begin
                    if (gate_open) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (h_last && v_last) begin
                        state_q <= enable ? ST_LATCH : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vsync       = vsync_q;
    assign hsync       = hsync_q;
    assign de          = de_q;
    assign x_pos       = x_pos_q;
    assign y_pos       = y_pos_q;
    assign frame_start = frame_start_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_vout_timing_gen.sv
// Directed bench for vout_timing_gen: pixel scoreboard plus a raster model for the 8/2/3/1 x 4/1/2/1 mode.
module tb_vout_timing_gen;

    localparam int unsigned CW = 12;
    localparam int HT = 14;
    localparam int VT = 8;

    logic          pclk = 1'b0;
    logic          prst;
    logic          enable;
    logic [CW-1:0] h_active, h_fp, h_sync, h_bp;
    logic [CW-1:0] v_active, v_fp, v_sync, v_bp;
    logic          hs_pol, vs_pol;
    logic          out_not_ready;
    logic          vsync, hsync, de, frame_start, cfg_err;
    logic [CW-1:0] x_pos, y_pos;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fs_cyc = 0;
    int de_cnt = 0;
    int fs1, fs2;
    logic rast_en = 1'b0;
    logic rast_pol = 1'b1;
    logic [2*CW-1:0] sb[$];

    // monitor scratch
    logic [2*CW-1:0] exp_xy;
    int m_t, m_l, m_h;
    logic e_de, e_hs, e_vs;

    vout_timing_gen dut (
        .pclk          (pclk),
        .prst          (prst),
        .enable        (enable),
        .h_active      (h_active),
        .h_fp          (h_fp),
        .h_sync        (h_sync),
        .h_bp          (h_bp),
        .v_active      (v_active),
        .v_fp          (v_fp),
        .v_sync        (v_sync),
        .v_bp          (v_bp),
        .hs_pol        (hs_pol),
        .vs_pol        (vs_pol),
        .out_not_ready (out_not_ready),
        .vsync         (vsync),
        .hsync         (hsync),
        .de            (de),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .frame_start   (frame_start),
        .cfg_err       (cfg_err)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_geom(input int ha, input int hf, input int hs, input int hb,
                            input int va, input int vf, input int vs, input int vb,
                            input logic pol);
        h_active = CW'(ha); h_fp = CW'(hf); h_sync = CW'(hs); h_bp = CW'(hb);
        v_active = CW'(va); v_fp = CW'(vf); v_sync = CW'(vs); v_bp = CW'(vb);
        hs_pol = pol; vs_pol = pol;
    endtask

    task automatic push_frame(input int ha, input int va);
        for (int y = 0; y < va; y++)
            for (int x = 0; x < ha; x++)
                sb.push_back({CW'(x), CW'(y)});
    endtask

    task automatic wait_fs(input int budget, input string tag, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge pclk);
            if (frame_start === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check(tag, 64'(at >= 0), 64'd1);
    endtask

    // Pixel scoreboard and, when enabled, a cycle-by-cycle raster model keyed off frame_start.
    always @(negedge pclk) begin
        if (frame_start === 1'b1) fs_cyc = cyc;
        if (de === 1'b1) begin
            de_cnt++;
            check("sb_avail", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_xy = sb.pop_front();
                check("xy", 64'({x_pos, y_pos}), 64'(exp_xy));
            end
        end
        if (rast_en) begin
            m_t = cyc - fs_cyc;
            if (m_t < HT * VT) begin
                m_l  = m_t / HT;
                m_h  = m_t % HT;
                e_de = (m_h < 8) && (m_l < 4);
                e_hs = ((m_h >= 10) && (m_h < 13)) ^ ~rast_pol;
                e_vs = ((m_l >= 5) && (m_l < 7)) ^ ~rast_pol;
            end else begin
                e_de = 1'b0;
                e_hs = ~rast_pol;
                e_vs = ~rast_pol;
            end
            check("raster", 64'({de, hsync, vsync}), 64'({e_de, e_hs, e_vs}));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        prst = 1'b1;
        enable = 1'b0;
        out_not_ready = 1'b0;
        set_geom(8, 2, 3, 1, 4, 1, 2, 1, 1'b1);
        repeat (3) @(negedge pclk);
        check("reset_outs", 64'({vsync, hsync, de, frame_start, cfg_err, x_pos, y_pos}), 64'd0);
        prst = 1'b0;
        repeat (5) @(negedge pclk);
        check("idle_no_de", 64'(de), 64'd0);

        // Two back-to-back frames, active-high syncs, then enable drops mid-frame.
        push_frame(8, 4);
        push_frame(8, 4);
        de_cnt = 0;
        rast_pol = 1'b1;
        @(negedge pclk) enable = 1'b1;
        repeat (3) @(negedge pclk);
        check("lat_pre_de", 64'(de), 64'd0);
        @(negedge pclk);
        check("lat_first", 64'({de, frame_start}), 64'b11);
        fs1 = cyc;
        rast_en = 1'b1;
        wait_fs(200, "fs_p1b", fs2);
        check("frame_period", 64'(fs2 - fs1), 64'd114);
        enable = 1'b0;
        repeat (130) @(negedge pclk);
        check("p1_sb_empty", 64'(sb.size()), 64'd0);
        check("p1_de_count", 64'(de_cnt), 64'd64);
        check("p1_idle_sync", 64'({hsync, vsync}), 64'd0);
        rast_en = 1'b0;

        // Active-low syncs: inverted raster, high while idle.
        set_geom(8, 2, 3, 1, 4, 1, 2, 1, 1'b0);
        push_frame(8, 4);
        rast_pol = 1'b0;
        de_cnt = 0;
        @(negedge pclk) enable = 1'b1;
        wait_fs(10, "fs_p2", fs1);
        rast_en = 1'b1;
        enable = 1'b0;
        repeat (130) @(negedge pclk);
        check("p2_idle_sync_high", 64'({hsync, vsync}), 64'b11);
        check("p2_sb_empty", 64'(sb.size()), 64'd0);
        check("p2_de_count", 64'(de_cnt), 64'd32);
        rast_en = 1'b0;

        // Zero h_sync is rejected; fixing it clears cfg_err at the next latch.
        set_geom(8, 2, 0, 1, 4, 1, 2, 1, 1'b0);
        de_cnt = 0;
        @(negedge pclk) enable = 1'b1;
        @(negedge pclk);
        check("cfg_err_pre", 64'(cfg_err), 64'd0);
        @(negedge pclk);
        check("cfg_err_set", 64'(cfg_err), 64'd1);
        repeat (20) @(negedge pclk);
        check("cfg_err_hold", 64'(cfg_err), 64'd1);
        check("cfg_no_de", 64'(de_cnt), 64'd0);
        push_frame(8, 4);
        h_sync = CW'(3);
        wait_fs(10, "fs_p3", fs1);
        check("cfg_err_clr", 64'(cfg_err), 64'd0);
        enable = 1'b0;
        repeat (130) @(negedge pclk);
        check("p3_sb_empty", 64'(sb.size()), 64'd0);

        // h_active changed mid-frame only affects the following frame.
        set_geom(8, 2, 3, 1, 4, 1, 2, 1, 1'b1);
        push_frame(8, 4);
        push_frame(6, 4);
        de_cnt = 0;
        @(negedge pclk) enable = 1'b1;
        wait_fs(10, "fs_p4a", fs1);
        repeat (20) @(negedge pclk);
        h_active = CW'(6);
        wait_fs(200, "fs_p4b", fs2);
        check("p4_period", 64'(fs2 - fs1), 64'd114);
        enable = 1'b0;
        repeat (120) @(negedge pclk);
        check("p4_sb_empty", 64'(sb.size()), 64'd0);
        check("p4_de_count", 64'(de_cnt), 64'd56);

        set_geom(8, 2, 3, 1, 4, 1, 2, 1, 1'b1);
`ifdef VOUT_TG_FRAME_GATE_EN
        // Downstream not ready holds the frame; release starts it two cycles later.
        out_not_ready = 1'b1;
        push_frame(8, 4);
        @(negedge pclk) enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            check("gate_hold", 64'({de, hsync, vsync, frame_start}), 64'd0);
        end
        out_not_ready = 1'b0;
        @(negedge pclk);
        check("gate_rel1", 64'(frame_start), 64'd0);
        @(negedge pclk);
        check("gate_rel2", 64'(frame_start), 64'd1);
`else
        // Without the gate, out_not_ready has no effect on frame start latency.
        out_not_ready = 1'b1;
        push_frame(8, 4);
        @(negedge pclk) enable = 1'b1;
        repeat (3) @(negedge pclk);
        check("nogate_pre", 64'(frame_start), 64'd0);
        @(negedge pclk);
        check("nogate_fs", 64'(frame_start), 64'd1);
`endif
        enable = 1'b0;
        out_not_ready = 1'b0;
        repeat (130) @(negedge pclk);
        check("p5_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset mid-frame at line 2, pixel 5; fresh frame afterwards.
        push_frame(8, 4);
        @(negedge pclk) enable = 1'b1;
        wait_fs(10, "fs_p6a", fs1);
        repeat (33) @(negedge pclk);
        check("pre_rst_xy", 64'({de, x_pos, y_pos}), 64'({1'b1, CW'(5), CW'(2)}));
        #1 prst = 1'b1;
        #1 check("async_rst", 64'({vsync, hsync, de, frame_start, cfg_err, x_pos, y_pos}), 64'd0);
        sb.delete();
        push_frame(8, 4);
        repeat (3) @(negedge pclk);
        check("rst_held_de", 64'(de), 64'd0);
        prst = 1'b0;
        wait_fs(10, "fs_p6b", fs2);
        check("post_rst_xy", 64'({de, x_pos, y_pos}), 64'({1'b1, CW'(0), CW'(0)}));
        enable = 1'b0;
        repeat (130) @(negedge pclk);
        check("p6_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vout_timing_gen.md
# vout_timing_gen

Programmable raster timing generator that drives `invsync`/`inhsync`/`inde` of the discontinuous video-out stage, which sits directly downstream. It produces one frame of sync/DE per configured geometry and emits pixel coordinates and a frame-start strobe. It can optionally hold off a new frame until the downstream line FIFO reports ready.

## Interface
Parameters:
- `CW`, 12: width of every geometry field and of the coordinate outputs.
- `TW`, 14: internal counter width. Must be ≥ CW+2 so that a 4-field sum cannot overflow.

Ports:
- `pclk` in 1: pixel clock, the only clock.
- `prst` in 1: reset, asynchronous, active-high.
- `enable` in 1: run request. Level-sensitive.
- `h_active`, `h_fp`, `h_sync`, `h_bp` in CW each: horizontal field lengths in pixels.
- `v_active`, `v_fp`, `v_sync`, `v_bp` in CW each: vertical field lengths in lines.
- `hs_pol`, `vs_pol` in 1 each: 1 selects active-high sync, 0 selects active-low.
- `out_not_ready` in 1: downstream FIFO empty/not-ready flag.
- `vsync`, `hsync`, `de` out 1 each: raster timing, registered.
- `x_pos`, `y_pos` out CW each: active coordinates. Valid while `de`=1; hold 0 otherwise.
- `frame_start` out 1: one-cycle pulse, coincident with the first `de` of each frame.
- `cfg_err` out 1: geometry rejected at the last latch point.

## Operation
- FSM states: IDLE, LATCH, WAIT_RDY, RUN.
  - IDLE→LATCH when `enable`=1.
  - LATCH: captures all 10 geometry/polarity inputs into shadow registers.
    - → IDLE with `cfg_err`=1 if any of `h_active`, `h_sync`, `v_active`, `v_sync` is 0.
    - Otherwise `cfg_err`←0 and → WAIT_RDY.
  - WAIT_RDY→RUN on the first cycle with the gate open (see Configuration).
  - RUN→LATCH at the last pixel of the frame if `enable`=1; →IDLE if `enable`=0.
- Shadow registers change only in LATCH. Mid-frame input changes take effect at the next frame.
- Counters `hc`, `vc`, each TW bits, zeroed on entry to RUN.
  - `hc` runs 0..HT-1, where HT = h_active+h_fp+h_sync+h_bp. Sums are computed at TW width.
  - `vc` increments when `hc` wraps, over 0..VT-1 (VT is the analogous vertical sum).
- Line order is active, fp, sync, bp. Frame order is active lines, fp, sync, bp.
- `de` = RUN and hc<h_active and vc<v_active.
- Raw hsync = h_active+h_fp ≤ hc < h_active+h_fp+h_sync. It is asserted on every line, including blanking lines.
- Raw vsync = v_active+v_fp ≤ vc < v_active+v_fp+v_sync. It is line-aligned (changes when hc=0).
- Output sync = raw XOR ~pol, taken from the shadow polarity. In IDLE/LATCH/WAIT_RDY, sync outputs are at their inactive level and `de`=0.
- `x_pos`=hc and `y_pos`=vc, truncated to CW bits, while `de`. They are 0 otherwise.
- `enable` falling mid-frame: the current frame completes, then the block idles. Outputs are never truncated.
- `prst` asserted mid-frame: the block aborts immediately to reset values.

## Timing
- Reset values: `vsync`=`hsync`=`de`=`frame_start`=`cfg_err`=0, `x_pos`=`y_pos`=0, FSM=IDLE, counters=0.
  - On the first clock after reset release, sync outputs take their inactive level.
- All outputs are registered. An output reflects counter state (hc, vc) one cycle later.
- `enable` rise→LATCH is 1 cycle. LATCH→WAIT_RDY is 1 cycle. With the gate open, WAIT_RDY→RUN is 1 cycle.
  - First `de` and `frame_start` occur 4 cycles after the `enable` rising edge is sampled.
- Back-to-back frames have 2 gap cycles (LATCH, WAIT_RDY) after the last bp pixel. Sync is inactive and `de`=0 during the gap.
- HT=1 or VT=1 cannot occur, because zero-check forces the sums ≥2.

## Configuration
- `VOUT_TG_FRAME_GATE_EN` defined: WAIT_RDY holds while `out_not_ready`=1 and advances on the first cycle `out_not_ready`=0.
  - This gates frames only; once RUN is entered, `out_not_ready` is ignored until the next frame boundary.
- Undefined: WAIT_RDY always advances after 1 cycle. `out_not_ready` is unused (port retained).

## Structure
- Shared package `vout_pkg`:
  - FSM state enum.
  - geometry struct `vout_geom_t` (8 CW fields + 2 polarities).
  - constant `VOUT_TW`.
- One sub-module: `vout_axis_cnt`, instantiated twice (horizontal, vertical). It contains a wrap counter plus an in-range decoder (active, sync) for one axis.

## Test plan
- h 8/2/3/1, v 4/1/2/1, pols=1, gate open:
  - `de` is high 8 cycles per line and 32 per frame.
  - `frame_start` recurs every 114 cycles (112 + 2-cycle gap).
  - `hsync` is high for hc 10..12 on every line.
  - `vsync` is high for lines 5..6.
- Same geometry with pols=0: `hsync`/`vsync` are inverted and are high in idle. `de` is unchanged.
- `h_sync`=0 with `enable`=1: `cfg_err`=1 within 2 cycles, the block returns to IDLE, and `de` never asserts. Correcting the field clears `cfg_err` at the next LATCH.
- Change `h_active` 8→6 mid-frame: the current frame keeps 8-pixel lines. The next frame shows 6-pixel `de` and `x_pos` max 5.
- With the macro defined, hold `out_not_ready`=1 for 20 cycles at a boundary: no `de` and inactive syncs for 20 cycles. `frame_start` appears on the 2nd cycle after release.
- `prst` pulsed at hc=5 of line 2: all outputs go to reset values asynchronously. After release with `enable` held, a fresh frame starts at x_pos=0, y_pos=0.
